switch_allocator: RTL and testbench



---
 rtl/noc_params_pkg.sv | 27 ++
 rtl/switch_allocator_if.sv | 24 ++
 rtl/round_robin_arbiter.sv | 40 ++++
 rtl/switch_allocator.sv | 131 +++++++++++++
 tb/tb_switch_allocator.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/noc_params_pkg.sv
// Shared router parameters and types: port enumeration, VC/port index widths, credit width.
package noc_params;

  localparam int PORT_NUM    = 5;
  localparam int VC_NUM      = 2;
  localparam int VC_TOTAL    = PORT_NUM * VC_NUM;
  localparam int BUFFER_SIZE = 8;

  localparam int PORT_SIZE = $clog2(PORT_NUM);
  localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  // A counter must hold every value from 0 up to and including the buffer depth.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CREDIT_SIZE = credit_width(BUFFER_SIZE);

  typedef enum logic [PORT_SIZE-1:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

endpackage

// File: rtl/switch_allocator_if.sv
// Allocator boundary: input-buffer requests and routes in, crossbar/buffer controls out.
interface switch_allocator_if;
  import noc_params::*;

  logic  [VC_TOTAL-1:0]               request_i;
  port_t [VC_TOTAL-1:0]               out_port_i;
  logic  [VC_TOTAL-1:0][VC_SIZE-1:0]  downstream_vc_i;
  logic  [VC_TOTAL-1:0]               credit_i;
  logic  [VC_TOTAL-1:0]               read_o;
  logic  [PORT_NUM-1:0][VC_SIZE-1:0]  in_vc_sel_o;
  logic  [PORT_NUM-1:0][PORT_SIZE-1:0] xbar_sel_o;
  logic  [PORT_NUM-1:0]               valid_flit_o;

  modport master (
    output request_i, out_port_i, downstream_vc_i, credit_i,
    input  read_o, in_vc_sel_o, xbar_sel_o, valid_flit_o
  );

  modport slave (
    input  request_i, out_port_i, downstream_vc_i, credit_i,
    output read_o, in_vc_sel_o, xbar_sel_o, valid_flit_o
  );

endinterface

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with one-hot grant; the pointer moves past the winner only when update_i is set.
module round_robin_arbiter #(
  parameter int AGENTS_NUM = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AGENTS_NUM-1:0] requests_i,
  input  logic                  update_i,
  output logic [AGENTS_NUM-1:0] grants_o
);

  localparam int PTR_W = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;

  logic [PTR_W-1:0] ptr, ptr_nxt;

  function automatic int wrap(input int v);
    return v % AGENTS_NUM;
  endfunction

  // Scan from the farthest offset down so the requester closest to ptr wins last.
  always_comb begin
    grants_o = '0;
    ptr_nxt  = ptr;
    for (int k = AGENTS_NUM - 1; k >= 0; k--) begin
      if (requests_i[wrap(int'(ptr) + k)]) begin
        grants_o = '0;
        grants_o[wrap(int'(ptr) + k)] = 1'b1;
        ptr_nxt = PTR_W'(wrap(int'(ptr) + k + 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (update_i && |grants_o)
      ptr <= ptr_nxt;
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator (iSLIP pointer update) with per-downstream-VC credit counters.
module switch_allocator
  import noc_params::*;
(
  input  logic               clk,
  input  logic               rst,
  switch_allocator_if.slave  sa
);

  logic [VC_TOTAL-1:0][CREDIT_SIZE-1:0] credit;
  logic [VC_TOTAL-1:0]                  eligible;
  logic [VC_TOTAL-1:0]                  final_grant;
  logic [VC_TOTAL-1:0]                  credit_dec;

  logic  [PORT_NUM-1:0][VC_NUM-1:0]  in_grant;
  logic  [PORT_NUM-1:0]              in_valid;
  logic  [PORT_NUM-1:0]              in_update;
  logic  [PORT_NUM-1:0][VC_SIZE-1:0] in_vc;
  port_t [PORT_NUM-1:0]              in_dest;

  // Indexed [output port][input port].
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  out_req;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  out_grant;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_sel;
  logic [PORT_NUM-1:0]                out_valid;

  function automatic int credit_idx(input port_t p, input logic [VC_SIZE-1:0] v);
    return int'(p) * VC_NUM + int'(v);
  endfunction

  function automatic logic [CREDIT_SIZE-1:0] credit_next(
    input logic [CREDIT_SIZE-1:0] c, input logic dec, input logic ret);
    logic [CREDIT_SIZE-1:0] r;
    r = c;
    if (dec && !ret)
      r = c - 1'b1;
    else if (!dec && ret && c != CREDIT_SIZE'(BUFFER_SIZE))
      r = c + 1'b1;
    return r;
  endfunction

  always_comb begin
    eligible = '0;
    for (int i = 0; i < VC_TOTAL; i++)
      eligible[i] = sa.request_i[i] &&
        (credit[credit_idx(sa.out_port_i[i], sa.downstream_vc_i[i])] != '0);
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_in_arb
    round_robin_arbiter #(.AGENTS_NUM(VC_NUM)) u_arb (
      .clk        (clk),
      .rst        (rst),
      .requests_i (eligible[p*VC_NUM +: VC_NUM]),
      .update_i   (in_update[p]),
      .grants_o   (in_grant[p])
    );
  end

  always_comb begin
    in_valid = '0;
    in_vc    = '0;
    out_req  = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      in_dest[p]  = LOCAL;
      in_valid[p] = |in_grant[p];
      for (int v = 0; v < VC_NUM; v++)
        if (in_grant[p][v]) in_vc[p] = VC_SIZE'(v);
      in_dest[p] = sa.out_port_i[p*VC_NUM + int'(in_vc[p])];
      for (int o = 0; o < PORT_NUM; o++)
        out_req[o][p] = in_valid[p] && (in_dest[p] == port_t'(o));
    end
  end

  // An output pointer moves whenever anything requests it, since a request always yields a grant.
  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out_arb
    round_robin_arbiter #(.AGENTS_NUM(PORT_NUM)) u_arb (
      .clk        (clk),
      .rst        (rst),
      .requests_i (out_req[o]),
      .update_i   (|out_req[o]),
      .grants_o   (out_grant[o])
    );
  end

  always_comb begin
    in_update   = '0;
    final_grant = '0;
    credit_dec  = '0;
    out_sel     = '0;
    out_valid   = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      out_valid[o] = |out_grant[o];
      for (int p = 0; p < PORT_NUM; p++) begin
        if (out_grant[o][p]) begin
          out_sel[o]   = PORT_SIZE'(p);
          in_update[p] = 1'b1;
          final_grant[p*VC_NUM + int'(in_vc[p])] = 1'b1;
          credit_dec[o*VC_NUM + int'(sa.downstream_vc_i[p*VC_NUM + int'(in_vc[p])])] = 1'b1;
        end
      end
    end
  end

  assign sa.read_o = rst ? '0 : final_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < VC_TOTAL; c++)
        credit[c] <= CREDIT_SIZE'(BUFFER_SIZE);
    end else begin
      for (int c = 0; c < VC_TOTAL; c++)
        credit[c] <= credit_next(credit[c], credit_dec[c], sa.credit_i[c]);
    end
  end

  // Selects hold their last value when idle; valid_flit_o qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa.valid_flit_o <= '0;
      sa.xbar_sel_o   <= '0;
      sa.in_vc_sel_o  <= '0;
    end else begin
      sa.valid_flit_o <= out_valid;
      for (int o = 0; o < PORT_NUM; o++)
        if (out_valid[o]) sa.xbar_sel_o[o] <= out_sel[o];
      for (int p = 0; p < PORT_NUM; p++)
        if (in_update[p]) sa.in_vc_sel_o[p] <= in_vc[p];
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: grant latency, credit exhaustion/return, round-robin, reset.
module tb_switch_allocator;
  import noc_params::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_allocator_if sa_if ();

  switch_allocator dut (
    .clk (clk),
    .rst (rst),
    .sa  (sa_if)
  );

  int total = 0;
  int bad   = 0;
  int n;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sa_if.request_i = '0;
    sa_if.credit_i  = '0;
    for (int i = 0; i < VC_TOTAL; i++) begin
      sa_if.out_port_i[i]      = LOCAL;
      sa_if.downstream_vc_i[i] = '0;
    end
  endtask

  task automatic route(input int vc, input port_t op, input int dvc);
    sa_if.out_port_i[vc]      = op;
    sa_if.downstream_vc_i[vc] = VC_SIZE'(dvc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic count_grants(input int vc, input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      #1;
      if (sa_if.read_o[vc]) cnt++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a live request that must stay masked
    idle();
    sa_if.request_i[0] = 1'b1;
    route(0, EAST, 1);
    tick();
    #1;
    chk("rst_read", 32'(sa_if.read_o), 32'h0);
    tick();
    chk("rst_valid", 32'(sa_if.valid_flit_o), 32'h0);
    chk("rst_xbar", 32'(sa_if.xbar_sel_o), 32'h0);
    chk("rst_invc", 32'(sa_if.in_vc_sel_o), 32'h0);

    // Single grant: LOCAL vc0 -> EAST vc1
    rst = 1'b0;
    #1;
    chk("t1_read", 32'(sa_if.read_o), 32'h1);
    tick();
    sa_if.request_i = '0;
    chk("t1_valid", 32'(sa_if.valid_flit_o), 32'h10);
    chk("t1_xbar", 32'(sa_if.xbar_sel_o[EAST]), 32'(LOCAL));
    chk("t1_invc", 32'(sa_if.in_vc_sel_o[LOCAL]), 32'h0);
    #1;
    chk("t1_read_off", 32'(sa_if.read_o), 32'h0);
    tick();
    chk("t1_valid_off", 32'(sa_if.valid_flit_o), 32'h0);

    // Credit exhaustion: NORTH vc0 -> SOUTH vc0
    route(2, SOUTH, 0);
    sa_if.request_i[2] = 1'b1;
    count_grants(2, 12, n);
    chk("t2_grants", 32'(n), 32'd8);
    chk("t2_empty", 32'(sa_if.read_o[2]), 32'h0);
    sa_if.credit_i[4] = 1'b1;
    #1;
    chk("t2_pulse_cycle", 32'(sa_if.read_o[2]), 32'h0);
    tick();
    sa_if.credit_i[4] = 1'b0;
    #1;
    chk("t2_regrant", 32'(sa_if.read_o[2]), 32'h1);
    tick();
    #1;
    chk("t2_one_only", 32'(sa_if.read_o[2]), 32'h0);
    sa_if.request_i = '0;

    // Grant and credit return on the same counter: SOUTH vc0 -> WEST vc1
    idle();
    route(4, WEST, 1);
    sa_if.request_i[4] = 1'b1;
    sa_if.credit_i[7]  = 1'b1;
    count_grants(4, 20, n);
    chk("t3_steady", 32'(n), 32'd20);
    sa_if.credit_i[7] = 1'b0;
    count_grants(4, 12, n);
    chk("t3_still_full", 32'(n), 32'd8);

    // Every port's vc0 -> NORTH vc0, credit returned each cycle
    do_reset();
    for (int p = 0; p < PORT_NUM; p++) begin
      route(2 * p, NORTH, 0);
      sa_if.request_i[2 * p] = 1'b1;
    end
    sa_if.credit_i[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("t4_read%0d", k), 32'(sa_if.read_o), 32'(1) << (2 * (k % 5)));
      if (k > 0) begin
        chk($sformatf("t4_xbar%0d", k), 32'(sa_if.xbar_sel_o[NORTH]), 32'((k - 1) % 5));
        chk($sformatf("t4_valid%0d", k), 32'(sa_if.valid_flit_o[NORTH]), 32'h1);
      end
      tick();
    end

    // WEST vc0 -> LOCAL, WEST vc1 -> EAST: input VC alternates
    do_reset();
    route(6, LOCAL, 0);
    route(7, EAST, 0);
    sa_if.request_i[6] = 1'b1;
    sa_if.request_i[7] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t5_read%0d", k), 32'(sa_if.read_o), 32'(1) << (6 + k % 2));
      if (k > 0)
        chk($sformatf("t5_invc%0d", k), 32'(sa_if.in_vc_sel_o[WEST]), 32'((k - 1) % 2));
      tick();
    end

    // Reset mid-stream after 3 grants
    do_reset();
    route(0, EAST, 0);
    sa_if.request_i[0] = 1'b1;
    count_grants(0, 3, n);
    chk("t6_pre", 32'(n), 32'd3);
    rst = 1'b1;
    #1;
    chk("t6_rst_read", 32'(sa_if.read_o), 32'h0);
    tick();
    chk("t6_rst_valid", 32'(sa_if.valid_flit_o), 32'h0);
    chk("t6_rst_xbar", 32'(sa_if.xbar_sel_o), 32'h0);
    chk("t6_rst_invc", 32'(sa_if.in_vc_sel_o), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < VC_TOTAL; i++) route(i, LOCAL, 0);
    sa_if.request_i = '1;
    #1;
    chk("t6_ptr", 32'(sa_if.read_o), 32'h1);
    tick();
    idle();
    route(0, EAST, 0);
    sa_if.request_i[0] = 1'b1;
    count_grants(0, 12, n);
    chk("t6_refill", 32'(n), 32'd8);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
